alu_share_arbiter: RTL

- Shares one combinational 4-bit operator unit between two requesters.
- Each requester issues an opcode and operands a, b, c, d through a valid/ready handshake.
- A round-robin arbiter grants the unit and a small FSM sequences accept, execute and respond.
- Results return on one shared response channel tagged with the requester id. The block sits between the operator datapath and its two client blocks.

---
 rtl/alu_share_pkg.sv | 25 ++
 rtl/alu_op_unit.sv | 33 +++
 rtl/alu_share_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_share_pkg.sv
// Shared types for the two-requester ALU arbiter: opcode map, FSM states, requester count.
package alu_share_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned NREQ = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SHR  = 4'd1,
    OP_GT   = 4'd2,
    OP_EQ   = 4'd3,
    OP_AND  = 4'd4,
    OP_RAND = 4'd5,
    OP_LOR  = 4'd6,
    OP_CAT  = 4'd7,
    OP_MAX  = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

endpackage

// File: rtl/alu_op_unit.sv
// Combinational operator unit; opcodes outside the map yield zero with err set.
module alu_op_unit
  import alu_share_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [W-1:0]    c,
  input  logic [W-1:0]    d,
  output logic [W-1:0]    y,
  output logic            err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_ADD:  y    = b + c;
      OP_SHR:  y    = b >> c;
      OP_GT:   y[0] = (a > b);
      OP_EQ:   y[0] = (a == b);
      OP_AND:  y    = b & c;
      OP_RAND: y[0] = &b;
      OP_LOR:  y[0] = (a > b) || (a > d);
      OP_CAT:  y    = {c[W/2-1:0], d[W-1:W/2]};
      OP_MAX:  y    = (a > b) ? a : b;
      default: err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one alu_op_unit between two valid/ready requesters.
// Optional macro ALU_SHARE_STATS_EN adds saturating per-requester grant counters.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_op,
  input  logic [NREQ*W-1:0]    req_a,
  input  logic [NREQ*W-1:0]    req_b,
  input  logic [NREQ*W-1:0]    req_c,
  input  logic [NREQ*W-1:0]    req_d,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [W-1:0]         rsp_data,
  output logic                 rsp_err
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [7:0]           grant_cnt0,
  output logic [7:0]           grant_cnt1
`endif
);

  state_e          state, state_nxt;
  logic            last_grant;
  logic            gnt;
  logic            accept;
  logic [OP_W-1:0] op_q;
  logic [W-1:0]    a_q, b_q, c_q, d_q;
  logic            id_q;
  logic [W-1:0]    alu_y;
  logic            alu_err;

  always_comb begin
    gnt       = (&req_valid) ? ~last_grant : req_valid[1];
    req_ready = '0;
    accept    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready[gnt] = 1'b1;
          accept         = 1'b1;
          state_nxt      = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q       <= req_op[OP_W*gnt +: OP_W];
        a_q        <= req_a[W*gnt +: W];
        b_q        <= req_b[W*gnt +: W];
        c_q        <= req_c[W*gnt +: W];
        d_q        <= req_d[W*gnt +: W];
        id_q       <= gnt;
        last_grant <= gnt;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_y;
        rsp_err   <= alu_err;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  alu_op_unit #(.W(W)) u_alu (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .c   (c_q),
    .d   (d_q),
    .y   (alu_y),
    .err (alu_err)
  );

`ifdef ALU_SHARE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (!gnt && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 8'd1;
      if (gnt && grant_cnt1 != '1)  grant_cnt1 <= grant_cnt1 + 8'd1;
    end
  end
`endif

endmodule
